// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) constants and the codeword-to-data mapping used by encoder and decoder.
package hamming_pkg;

  localparam int unsigned DATA_W = 11;
  localparam int unsigned CODE_W = 15;
  localparam int unsigned SYN_W  = 4;

  // Parity bit indices (codeword positions 1, 2, 4, 8).
  localparam int unsigned P1_IDX = 0;
  localparam int unsigned P2_IDX = 1;
  localparam int unsigned P4_IDX = 3;
  localparam int unsigned P8_IDX = 7;

  // Gathers the 11 data bits from the non-parity positions of a codeword.
  function automatic logic [DATA_W-1:0] extrai_dados(input logic [CODE_W-1:0] c);
    return {c[14:8], c[6:4], c[2]};
  endfunction

endpackage

// File: rtl/calcula_sindrome.sv
// Combinational Hamming(15,11) syndrome: each bit is the parity of the positions it covers.
module calcula_sindrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] codigo,
  output logic [SYN_W-1:0]  sindrome
);

  // Masks select indices whose 1-based position has the matching syndrome bit set.
  localparam logic [CODE_W-1:0] MASCARA_S1 = 15'h5555;
  localparam logic [CODE_W-1:0] MASCARA_S2 = 15'h6666;
  localparam logic [CODE_W-1:0] MASCARA_S4 = 15'h7878;
  localparam logic [CODE_W-1:0] MASCARA_S8 = 15'h7F80;

  assign sindrome = {^(codigo & MASCARA_S8), ^(codigo & MASCARA_S4),
                     ^(codigo & MASCARA_S2), ^(codigo & MASCARA_S1)};

endmodule

// File: rtl/decodifica_hamming.sv
// Two-stage Hamming(15,11) SEC decoder with valid/ready flow control and a saturating
// counter of delivered corrected words.
module decodifica_hamming
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CODE_W-1:0]    entrada,
  input  logic                 entrada_valida,
  output logic                 entrada_pronta,
  output logic [DATA_W-1:0]    saida,
  output logic                 saida_valida,
  input  logic                 saida_pronta,
  output logic                 erro_corrigido,
  output logic [SYN_W-1:0]     sindrome,
  input  logic                 limpa_contador,
  output logic [CNT_W-1:0]     contador_correcoes
);

  logic              valid1, valid2;
  logic              adv1, adv2;
  logic [CODE_W-1:0] cod1;
  logic [SYN_W-1:0]  sin_comb, sin1;
  logic [CODE_W-1:0] corrigido;

  // Each stage may load when it is empty or its content moves on this cycle.
  assign adv2           = !valid2 || saida_pronta;
  assign adv1           = !valid1 || adv2;
  assign entrada_pronta = adv1;
  assign saida_valida   = valid2;

  calcula_sindrome u_sindrome (
    .codigo   (entrada),
    .sindrome (sin_comb)
  );

  // Stage 1: capture received codeword and its syndrome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1 <= 1'b0;
      cod1   <= '0;
      sin1   <= '0;
    end else if (adv1) begin
      valid1 <= entrada_valida;
      if (entrada_valida) begin
        cod1 <= entrada;
        sin1 <= sin_comb;
      end
    end
  end

  // Flip the bit addressed by a nonzero syndrome; zero leaves the word untouched.
  always_comb begin
    corrigido = cod1;
    for (int i = 0; i < CODE_W; i++) begin
      if (sin1 == SYN_W'(i + 1)) corrigido[i] = ~cod1[i];
    end
  end

  // Stage 2: register corrected data and status; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid2         <= 1'b0;
      saida          <= '0;
      sindrome       <= '0;
      erro_corrigido <= 1'b0;
    end else if (adv2) begin
      valid2 <= valid1;
      if (valid1) begin
        saida          <= extrai_dados(corrigido);
        sindrome       <= sin1;
        erro_corrigido <= (sin1 != '0);
      end
    end
  end

  // Count delivered corrected words, saturating; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador_correcoes <= '0;
    end else if (limpa_contador) begin
      contador_correcoes <= '0;
    end else if (valid2 && saida_pronta && erro_corrigido && (contador_correcoes != '1)) begin
      contador_correcoes <= contador_correcoes + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decodifica_hamming.sv
// Self-checking bench for decodifica_hamming: vector table, scoreboard, stall/reset corners.
module tb_decodifica_hamming;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [14:0]       entrada;
  logic              entrada_valida;
  logic              entrada_pronta;
  logic [10:0]       saida;
  logic              saida_valida;
  logic              saida_pronta;
  logic              erro_corrigido;
  logic [3:0]        sindrome;
  logic              limpa_contador;
  logic [CNT_W-1:0]  contador_correcoes;

  decodifica_hamming #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .entrada            (entrada),
    .entrada_valida     (entrada_valida),
    .entrada_pronta     (entrada_pronta),
    .saida              (saida),
    .saida_valida       (saida_valida),
    .saida_pronta       (saida_pronta),
    .erro_corrigido     (erro_corrigido),
    .sindrome           (sindrome),
    .limpa_contador     (limpa_contador),
    .contador_correcoes (contador_correcoes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] data;
    logic [3:0]  syn;
    logic        err;
  } saida_t;

  typedef struct {
    logic [14:0] code;
    saida_t      exp;
  } vetor_t;

  saida_t fila[$];
  saida_t esperado_entrada;
  int     aplicados;
  int     erros;
  int     popped;
  int     modelo_cnt;
  bit     modo_aleatorio;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    aplicados++;
    if (got !== exp) begin
      erros++;
      $display("FAIL %s: got %0h, required %0h", nome, got, exp);
    end
  endtask

  // Reference encoder: data into non-power-of-two positions, parity makes syndrome zero.
  function automatic logic [14:0] codifica(input logic [10:0] d);
    logic [14:0] c;
    logic [3:0]  s;
    int          k;
    c = '0;
    s = '0;
    k = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 15; p++) if (c[p-1]) s ^= 4'(p);
    c[0] = s[0];
    c[1] = s[1];
    c[3] = s[2];
    c[7] = s[3];
    return c;
  endfunction

  task automatic gera(input bit com_erro, output logic [14:0] c, output saida_t e);
    logic [10:0] d;
    int          idx;
    d = 11'($urandom);
    c = codifica(d);
    e.data = d;
    e.syn  = 4'd0;
    e.err  = 1'b0;
    if (com_erro) begin
      idx    = $urandom_range(0, 14);
      c[idx] = ~c[idx];
      e.syn  = 4'(idx + 1);
      e.err  = 1'b1;
    end
  endtask

  task automatic send(input logic [14:0] w, input saida_t e);
    int n;
    n = 0;
    entrada          = w;
    esperado_entrada = e;
    entrada_valida   = 1'b1;
    @(negedge clk);
    while (!entrada_pronta && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!entrada_pronta) begin
      aplicados++;
      erros++;
      $display("FAIL send_timeout: got entrada_pronta=0, required 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    entrada_valida = 1'b0;
  endtask

  task automatic drena();
    int n;
    n = 0;
    while ((fila.size() != 0 || saida_valida) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (fila.size() != 0 || saida_valida) begin
      aplicados++;
      erros++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", fila.size());
    end
  endtask

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push at input handshake, pop/compare at output handshake, model the counter.
  task automatic monitor();
    saida_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fila.delete();
        modelo_cnt = 0;
      end else begin
        if (saida_valida && saida_pronta) begin
          if (fila.size() == 0) begin
            aplicados++;
            erros++;
            $display("FAIL unexpected_word: got %0h, required no output", saida);
          end else begin
            e = fila.pop_front();
            popped++;
            check("saida", {saida, sindrome, erro_corrigido}, e);
            if (e.err && modelo_cnt < CNT_MAX) modelo_cnt++;
          end
        end
        if (limpa_contador) modelo_cnt = 0;
        if (entrada_valida && entrada_pronta) fila.push_back(esperado_entrada);
      end
    end
  endtask

  task automatic pronta_aleatoria();
    forever begin
      @(posedge clk);
      #1;
      if (modo_aleatorio) saida_pronta = 1'($urandom_range(0, 1));
    end
  endtask

  vetor_t      tabela[7];
  logic [14:0] c;
  saida_t      e;
  logic [15:0] snap;
  int          antes;

  initial begin
    aplicados = 0; erros = 0; popped = 0; modelo_cnt = 0; modo_aleatorio = 0;
    rst_n = 1'b0; entrada = '0; entrada_valida = 1'b0; saida_pronta = 1'b1;
    limpa_contador = 1'b0; esperado_entrada = '0;

    tabela[0] = '{15'h0007, '{11'h001, 4'd0,  1'b0}};
    tabela[1] = '{15'h7FDF, '{11'h7FF, 4'd6,  1'b1}};
    tabela[2] = '{15'h0001, '{11'h000, 4'd1,  1'b1}};
    tabela[3] = '{15'h0000, '{11'h000, 4'd0,  1'b0}};
    tabela[4] = '{15'h7FFF, '{11'h7FF, 4'd0,  1'b0}};
    tabela[5] = '{15'h4000, '{11'h000, 4'd15, 1'b1}};
    tabela[6] = '{15'h0004, '{11'h000, 4'd3,  1'b1}};

    fork
      monitor();
      pronta_aleatoria();
    join_none

    // Reset state.
    #12;
    check("rst_saida_valida", saida_valida, 0);
    check("rst_saida", saida, 0);
    check("rst_sindrome", sindrome, 0);
    check("rst_erro", erro_corrigido, 0);
    check("rst_contador", contador_correcoes, 0);
    check("rst_entrada_pronta", entrada_pronta, 1);
    @(negedge clk);
    rst_n = 1'b1;
    ciclo();

    // Latency: accepted at edge N, valid after edge N+1.
    send(15'h0007, '{11'h001, 4'd0, 1'b0});
    check("lat_not_yet", saida_valida, 0);
    ciclo();
    check("lat_valid", saida_valida, 1);
    drena();
    check("cnt_after_clean", contador_correcoes, 0);

    // Single corrected word moves counter 0 -> 1.
    send(tabela[1].code, tabela[1].exp);
    drena();
    check("cnt_after_7fdf", contador_correcoes, 1);

    // Table vectors back to back.
    for (int i = 0; i < 7; i++) send(tabela[i].code, tabela[i].exp);
    drena();
    check("cnt_after_table", contador_correcoes, 32'(modelo_cnt));

    // Stall: two words fill the pipe, third blocked, release drains one per cycle.
    limpa_contador = 1'b1;
    ciclo();
    limpa_contador = 1'b0;
    check("cnt_cleared", contador_correcoes, 0);
    saida_pronta = 1'b0;
    send(15'h0007, '{11'h001, 4'd0, 1'b0});
    send(15'h7FDF, '{11'h7FF, 4'd6, 1'b1});
    entrada = 15'h0001;
    esperado_entrada = '{11'h000, 4'd1, 1'b1};
    entrada_valida = 1'b1;
    @(negedge clk);
    check("full_pronta", entrada_pronta, 0);
    snap = {saida, sindrome, erro_corrigido};
    @(negedge clk);
    check("stall_stable", {saida, sindrome, erro_corrigido}, snap);
    check("full_pronta_hold", entrada_pronta, 0);
    antes = popped;
    ciclo();
    saida_pronta = 1'b1;
    send(15'h0001, '{11'h000, 4'd1, 1'b1});
    ciclo();
    ciclo();
    check("release_pops", popped, antes + 3);
    check("release_empty", saida_valida, 0);
    check("cnt_after_stall", contador_correcoes, 2);

    // Saturation: five corrected words on a 2-bit counter.
    limpa_contador = 1'b1;
    ciclo();
    limpa_contador = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gera(1'b1, c, e);
      send(c, e);
    end
    drena();
    check("cnt_saturated", contador_correcoes, CNT_MAX);

    // Clear coinciding with a corrected pop.
    saida_pronta = 1'b0;
    gera(1'b1, c, e);
    send(c, e);
    for (int n = 0; n < 10 && !saida_valida; n++) ciclo();
    check("sixth_ready", saida_valida, 1);
    saida_pronta = 1'b1;
    limpa_contador = 1'b1;
    ciclo();
    limpa_contador = 1'b0;
    check("cnt_clear_priority", contador_correcoes, 0);
    check("sixth_popped", fila.size(), 0);

    // Random traffic with random back-pressure.
    modo_aleatorio = 1'b1;
    for (int i = 0; i < 40; i++) begin
      gera(1'($urandom_range(0, 1)), c, e);
      send(c, e);
    end
    modo_aleatorio = 1'b0;
    saida_pronta = 1'b1;
    drena();
    check("cnt_after_random", contador_correcoes, 32'(modelo_cnt));

    // Reset with both stages full.
    saida_pronta = 1'b0;
    gera(1'b1, c, e);
    send(c, e);
    gera(1'b0, c, e);
    send(c, e);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", saida_valida, 0);
    check("midrst_cnt", contador_correcoes, 0);
    check("midrst_pronta", entrada_pronta, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    saida_pronta = 1'b1;
    ciclo();
    send(15'h7FDF, '{11'h7FF, 4'd6, 1'b1});
    drena();
    check("post_rst_cnt", contador_correcoes, 1);

    $display("== %0d vectors applied, %0d miscompares ==", aplicados, erros);
    $finish;
  end

endmodule
